// File: rtl/truth_table_sweeper_if.sv
// Stimulus/response bundle between the sweeper and the two implementations it compares.
// master drives start and the implementation outputs; slave is the sweeper itself.
interface truth_table_sweeper_if;
    logic       i_start;
    logic [4:0] i_y_dknf;
    logic [4:0] i_y_ddnf;
    logic [7:0] o_x;
    logic       o_busy;
    logic       o_done;
    logic       o_error;
    logic [8:0] o_err_cnt;
    logic [7:0] o_first_x;
    logic [4:0] o_first_dknf;
    logic [4:0] o_first_ddnf;

    modport master (
        output i_start, i_y_dknf, i_y_ddnf,
        input  o_x, o_busy, o_done, o_error, o_err_cnt, o_first_x, o_first_dknf, o_first_ddnf
    );

    modport slave (
        input  i_start, i_y_dknf, i_y_ddnf,
        output o_x, o_busy, o_done, o_error, o_err_cnt, o_first_x, o_first_dknf, o_first_ddnf
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks o_x through all 256 input vectors, lets both implementations settle, and
// compares their 5-bit outputs, recording the mismatch count and the first failure.
module truth_table_sweeper #(
    parameter int SETTLE_CYC  = 2,
    parameter int STOP_ON_ERR = 0
) (
    input logic                  clk,
    input logic                  rst,
    truth_table_sweeper_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, DONE} state_e;

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYC - 1);

    state_e     state_q;
    logic [3:0] settle_q;
    logic [7:0] x_q;
    logic       busy_q;
    logic       done_q;
    logic       error_q;
    logic [8:0] err_cnt_q;
    logic [8:0] err_cnt_d;
    logic [7:0] first_x_q;
    logic [4:0] first_dknf_q;
    logic [4:0] first_ddnf_q;
    logic       mismatch;

    assign mismatch  = (bus.i_y_dknf != bus.i_y_ddnf);
    assign err_cnt_d = (err_cnt_q == 9'd256) ? err_cnt_q : err_cnt_q + 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            x_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_cnt_q    <= '0;
            first_x_q    <= '0;
            first_dknf_q <= '0;
            first_ddnf_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.i_start) begin
                        state_q      <= SETTLE;
                        settle_q     <= RELOAD;
                        x_q          <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        err_cnt_q    <= '0;
                        first_x_q    <= '0;
                        first_dknf_q <= '0;
                        first_ddnf_q <= '0;
                    end
                end
                SETTLE: begin
                    if (settle_q == 4'd0) state_q <= COMPARE;
                    else                  settle_q <= settle_q - 4'd1;
                end
                COMPARE: begin
                    if (mismatch) begin
                        err_cnt_q <= err_cnt_d;
                        error_q   <= 1'b1;
                        // Only the first failing vector of a sweep is kept for debug.
                        if (err_cnt_q == 9'd0) begin
                            first_x_q    <= x_q;
                            first_dknf_q <= bus.i_y_dknf;
                            first_ddnf_q <= bus.i_y_ddnf;
                        end
                    end
                    if (x_q == 8'hFF || (STOP_ON_ERR != 0 && mismatch)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= SETTLE;
                        settle_q <= RELOAD;
                        x_q      <= x_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_x          = x_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_error      = error_q;
    assign bus.o_err_cnt    = err_cnt_q;
    assign bus.o_first_x    = first_x_q;
    assign bus.o_first_dknf = first_dknf_q;
    assign bus.o_first_ddnf = first_ddnf_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Two sweepers (run-to-end with SETTLE_CYC=2, stop-on-error with SETTLE_CYC=3) face
// table-driven implementations; results are checked against a per-vector sweep model.
module tb_truth_table_sweeper;
    localparam int S0 = 2;
    localparam int S1 = 3;

    logic clk = 1'b0;
    logic rst;
    int   errs   = 0;
    int   checks = 0;
    int   lat0, lat1;

    logic [4:0] ytab  [256];
    logic [4:0] mask0 [256];
    logic [4:0] mask1 [256];

    typedef struct {
        int cnt; int fx; int fd; int fdd; int endx; int lat;
    } exp_t;

    truth_table_sweeper_if ifc0 ();
    truth_table_sweeper_if ifc1 ();

    // Implementations under test: dknf is a random truth table, ddnf differs by the mask.
    assign ifc0.i_y_dknf = ytab[ifc0.o_x];
    assign ifc0.i_y_ddnf = ytab[ifc0.o_x] ^ mask0[ifc0.o_x];
    assign ifc1.i_y_dknf = ytab[ifc1.o_x];
    assign ifc1.i_y_ddnf = ytab[ifc1.o_x] ^ mask1[ifc1.o_x];

    truth_table_sweeper #(.SETTLE_CYC(S0), .STOP_ON_ERR(0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
    truth_table_sweeper #(.SETTLE_CYC(S1), .STOP_ON_ERR(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));

    always #5 clk = ~clk;

    // Sweep outcome from the rules: each vector is one compare costing settle+1 clocks.
    function automatic exp_t model(input bit stop, input int s);
        exp_t e;
        int n;
        logic [4:0] m;
        e = '{cnt: 0, fx: 0, fd: 0, fdd: 0, endx: 255, lat: 0};
        n = 0;
        for (int x = 0; x < 256; x++) begin
            m = stop ? mask1[x] : mask0[x];
            n++;
            if (m != 5'd0) begin
                if (e.cnt == 0) begin
                    e.fx  = x;
                    e.fd  = int'(ytab[x]);
                    e.fdd = int'(ytab[x] ^ m);
                end
                e.cnt++;
                if (stop) begin
                    e.endx = x;
                    break;
                end
            end
        end
        e.lat = n * (s + 1) + 1;
        return e;
    endfunction

    task automatic fill_tables(input int dens0, input int dens1);
        for (int x = 0; x < 256; x++) begin
            ytab[x]  = 5'($urandom_range(0, 31));
            mask0[x] = (dens0 > 0 && $urandom_range(0, dens0 - 1) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            mask1[x] = (dens1 > 0 && $urandom_range(0, dens1 - 1) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        end
    endtask

    // Start both sweepers together and record the start-to-done latency of each.
    task automatic run_sweep(input bit spam);
        int n;
        bit d0, d1;
        n = 0; d0 = 1'b0; d1 = 1'b0; lat0 = -1; lat1 = -1;
        @(negedge clk);
        ifc0.i_start = 1'b1;
        ifc1.i_start = 1'b1;
        while (!(d0 && d1) && n < 4000) begin
            @(negedge clk);
            n++;
            if (!d0 && ifc0.o_done) begin d0 = 1'b1; lat0 = n; end
            if (!d1 && ifc1.o_done) begin d1 = 1'b1; lat1 = n; end
            ifc0.i_start = spam && !d0;
            ifc1.i_start = spam && !d1;
        end
        ifc0.i_start = 1'b0;
        ifc1.i_start = 1'b0;
        checks++;
        if (!(d0 && d1)) begin
            errs++;
            $display("FAIL sweep_timeout: done0=%0b done1=%0b after %0d cycles, want both 1", d0, d1, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({ifc0.o_x, ifc0.o_busy, ifc0.o_done, ifc0.o_error, ifc0.o_err_cnt, ifc0.o_first_x,
             ifc0.o_first_dknf, ifc0.o_first_ddnf} !== 43'd0) begin
            errs++; $display("FAIL reset_dut0: outputs not all zero (x=%h busy=%b done=%b)", ifc0.o_x, ifc0.o_busy, ifc0.o_done);
        end
        checks++;
        if ({ifc1.o_x, ifc1.o_busy, ifc1.o_done, ifc1.o_error, ifc1.o_err_cnt, ifc1.o_first_x,
             ifc1.o_first_dknf, ifc1.o_first_ddnf} !== 43'd0) begin
            errs++; $display("FAIL reset_dut1: outputs not all zero (x=%h busy=%b done=%b)", ifc1.o_x, ifc1.o_busy, ifc1.o_done);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({ifc0.o_busy, ifc0.o_done, ifc1.o_busy, ifc1.o_done} !== 4'b0000) begin
            errs++; $display("FAIL reset_idle: busy/done=%b want 0000", {ifc0.o_busy, ifc0.o_done, ifc1.o_busy, ifc1.o_done});
        end
    endtask

    task automatic test_identical();
        exp_t e1;
        fill_tables(0, 0);
        e1 = model(1'b1, S1);
        run_sweep(1'b0);
        checks++;
        if (lat0 != 769) begin errs++; $display("FAIL ident_latency: got %0d want 769", lat0); end
        checks++;
        if ({ifc0.o_error, ifc0.o_err_cnt, ifc0.o_x, ifc0.o_busy} !== {1'b0, 9'd0, 8'hFF, 1'b0}) begin
            errs++; $display("FAIL ident_result: err=%b cnt=%0d x=%h busy=%b want 0 0 ff 0",
                             ifc0.o_error, ifc0.o_err_cnt, ifc0.o_x, ifc0.o_busy);
        end
        checks++;
        if (lat1 != e1.lat || ifc1.o_x !== 8'hFF || ifc1.o_error !== 1'b0) begin
            errs++; $display("FAIL ident_stop_dut: lat=%0d x=%h err=%b want %0d ff 0", lat1, ifc1.o_x, ifc1.o_error, e1.lat);
        end
    endtask

    task automatic test_single_5a();
        fill_tables(0, 0);
        mask0[8'h5A] = 5'b00001;
        run_sweep(1'b0);
        checks++;
        if ({ifc0.o_err_cnt, ifc0.o_first_x, ifc0.o_x, ifc0.o_error} !== {9'd1, 8'h5A, 8'hFF, 1'b1}) begin
            errs++; $display("FAIL single_result: cnt=%0d first_x=%h x=%h err=%b want 1 5a ff 1",
                             ifc0.o_err_cnt, ifc0.o_first_x, ifc0.o_x, ifc0.o_error);
        end
        checks++;
        if ((ifc0.o_first_dknf ^ ifc0.o_first_ddnf) !== 5'b00001 || ifc0.o_first_dknf !== ytab[8'h5A]) begin
            errs++; $display("FAIL single_capture: dknf=%h ddnf=%h want dknf=%h xor 01",
                             ifc0.o_first_dknf, ifc0.o_first_ddnf, ytab[8'h5A]);
        end
    endtask

    task automatic test_stop_on_err();
        exp_t e1;
        fill_tables(0, 0);
        mask0[8'h10] = 5'($urandom_range(1, 31)); mask0[8'h20] = 5'($urandom_range(1, 31));
        mask1[8'h10] = mask0[8'h10];              mask1[8'h20] = mask0[8'h20];
        e1 = model(1'b1, S1);
        run_sweep(1'b0);
        checks++;
        if ({ifc1.o_x, ifc1.o_err_cnt, ifc1.o_first_x} !== {8'h10, 9'd1, 8'h10}) begin
            errs++; $display("FAIL stop_result: x=%h cnt=%0d first_x=%h want 10 1 10", ifc1.o_x, ifc1.o_err_cnt, ifc1.o_first_x);
        end
        checks++;
        if (lat1 != e1.lat) begin errs++; $display("FAIL stop_latency: got %0d want %0d", lat1, e1.lat); end
        checks++;
        if (ifc0.o_err_cnt !== 9'd2 || ifc0.o_first_x !== 8'h10) begin
            errs++; $display("FAIL stop_nostop_dut: cnt=%0d first_x=%h want 2 10", ifc0.o_err_cnt, ifc0.o_first_x);
        end
    endtask

    task automatic test_all_inverted();
        exp_t e1;
        fill_tables(0, 0);
        for (int x = 0; x < 256; x++) begin mask0[x] = 5'h1F; mask1[x] = 5'h1F; end
        e1 = model(1'b1, S1);
        run_sweep(1'b0);
        checks++;
        if ({ifc0.o_err_cnt, ifc0.o_first_x, ifc0.o_error} !== {9'h100, 8'h00, 1'b1}) begin
            errs++; $display("FAIL inv_result: cnt=%h first_x=%h err=%b want 100 00 1", ifc0.o_err_cnt, ifc0.o_first_x, ifc0.o_error);
        end
        checks++;
        if (ifc0.o_first_ddnf !== ~ifc0.o_first_dknf || ifc0.o_first_dknf !== ytab[0]) begin
            errs++; $display("FAIL inv_capture: dknf=%h ddnf=%h want %h and its inverse", ifc0.o_first_dknf, ifc0.o_first_ddnf, ytab[0]);
        end
        checks++;
        if (ifc1.o_x !== 8'h00 || ifc1.o_err_cnt !== 9'd1 || lat1 != e1.lat) begin
            errs++; $display("FAIL inv_stop: x=%h cnt=%0d lat=%0d want 00 1 %0d", ifc1.o_x, ifc1.o_err_cnt, lat1, e1.lat);
        end
    endtask

    task automatic test_random();
        exp_t e0, e1;
        for (int r = 0; r < 3; r++) begin
            fill_tables(8 << r, 64);
            e0 = model(1'b0, S0);
            e1 = model(1'b1, S1);
            run_sweep(1'b0);
            checks++;
            if ({ifc0.o_err_cnt, ifc0.o_first_x, ifc0.o_first_dknf, ifc0.o_first_ddnf, ifc0.o_x, ifc0.o_error} !==
                {9'(e0.cnt), 8'(e0.fx), 5'(e0.fd), 5'(e0.fdd), 8'(e0.endx), e0.cnt != 0} || lat0 != e0.lat) begin
                errs++; $display("FAIL rand%0d_dut0: cnt=%0d fx=%h fd=%h fdd=%h x=%h lat=%0d want %0d %h %h %h %h %0d", r,
                                 ifc0.o_err_cnt, ifc0.o_first_x, ifc0.o_first_dknf, ifc0.o_first_ddnf, ifc0.o_x, lat0,
                                 e0.cnt, e0.fx, e0.fd, e0.fdd, e0.endx, e0.lat);
            end
            checks++;
            if ({ifc1.o_err_cnt, ifc1.o_first_x, ifc1.o_first_dknf, ifc1.o_first_ddnf, ifc1.o_x} !==
                {9'(e1.cnt), 8'(e1.fx), 5'(e1.fd), 5'(e1.fdd), 8'(e1.endx)} || lat1 != e1.lat) begin
                errs++; $display("FAIL rand%0d_dut1: cnt=%0d fx=%h fd=%h fdd=%h x=%h lat=%0d want %0d %h %h %h %h %0d", r,
                                 ifc1.o_err_cnt, ifc1.o_first_x, ifc1.o_first_dknf, ifc1.o_first_ddnf, ifc1.o_x, lat1,
                                 e1.cnt, e1.fx, e1.fd, e1.fdd, e1.endx, e1.lat);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        fill_tables(0, 0);
        mask0[3] = 5'h04; mask1[8'h90] = 5'h02;
        @(negedge clk);
        ifc0.i_start = 1'b1; ifc1.i_start = 1'b1;
        @(negedge clk);
        ifc0.i_start = 1'b0; ifc1.i_start = 1'b0;
        n = 0;
        while (ifc0.o_x !== 8'h80 && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (ifc0.o_x !== 8'h80) begin errs++; $display("FAIL midrst_reach: x=%h want 80", ifc0.o_x); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ifc0.o_x, ifc0.o_busy, ifc0.o_done, ifc0.o_error, ifc0.o_err_cnt, ifc0.o_first_x, ifc0.o_first_dknf,
             ifc0.o_first_ddnf, ifc1.o_x, ifc1.o_busy, ifc1.o_err_cnt} !== 61'd0) begin
            errs++; $display("FAIL midrst_async: x=%h busy=%b err=%b cnt=%0d first_x=%h want all zero",
                             ifc0.o_x, ifc0.o_busy, ifc0.o_error, ifc0.o_err_cnt, ifc0.o_first_x);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifc0.o_busy, ifc0.o_done, ifc0.o_x} !== 10'd0) begin
            errs++; $display("FAIL midrst_idle: busy=%b done=%b x=%h want 0 0 00", ifc0.o_busy, ifc0.o_done, ifc0.o_x);
        end
        mask0[3] = 5'h00; mask1[8'h90] = 5'h00;
        run_sweep(1'b0);
        checks++;
        if (lat0 != 769 || ifc0.o_err_cnt !== 9'd0 || ifc0.o_x !== 8'hFF) begin
            errs++; $display("FAIL midrst_clean: lat=%0d cnt=%0d x=%h want 769 0 ff", lat0, ifc0.o_err_cnt, ifc0.o_x);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e1;
        fill_tables(0, 0);
        mask0[7] = 5'h02; mask0[8'hC0] = 5'h11;
        e1 = model(1'b1, S1);
        run_sweep(1'b1);
        checks++;
        if (lat0 != 769 || ifc0.o_err_cnt !== 9'd2 || ifc0.o_first_x !== 8'h07) begin
            errs++; $display("FAIL b2b_spam: lat=%0d cnt=%0d fx=%h want 769 2 07", lat0, ifc0.o_err_cnt, ifc0.o_first_x);
        end
        checks++;
        if (lat1 != e1.lat) begin errs++; $display("FAIL b2b_spam_dut1: lat=%0d want %0d", lat1, e1.lat); end
        @(negedge clk);
        ifc0.i_start = 1'b1;
        @(negedge clk);
        ifc0.i_start = 1'b0;
        checks++;
        if ({ifc0.o_done, ifc0.o_error, ifc0.o_err_cnt, ifc0.o_first_x, ifc0.o_first_dknf, ifc0.o_first_ddnf,
             ifc0.o_x, ifc0.o_busy} !== {1'b0, 1'b0, 9'd0, 8'd0, 5'd0, 5'd0, 8'd0, 1'b1}) begin
            errs++; $display("FAIL b2b_restart: done=%b err=%b cnt=%0d fx=%h x=%h busy=%b want 0 0 0 00 00 1",
                             ifc0.o_done, ifc0.o_error, ifc0.o_err_cnt, ifc0.o_first_x, ifc0.o_x, ifc0.o_busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        ifc0.i_start = 1'b0;
        ifc1.i_start = 1'b0;
        test_reset();
        test_identical();
        test_single_5a();
        test_stop_on_err();
        test_all_inverted();
        test_random();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE_CYC, default 2, number of clocks o_x is held stable before outputs are sampled (legal 1..15).
REQ-002 Parameter STOP_ON_ERR, default 0, 1 = end the sweep at the first mismatch.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 i_start  input  1  sweep request, sampled in IDLE and DONE only.
REQ-006 i_y_dknf  input  5  output of the DKNF implementation under test.
REQ-007 i_y_ddnf  input  5  output of the DDNF implementation under test.
REQ-008 o_x  output  8  stimulus vector driven to both implementations.
REQ-009 o_busy  output  1  high while a sweep is in progress.
REQ-010 o_done  output  1  high in DONE, held until the next start or rst.
REQ-011 o_error  output  1  sticky, set on any mismatch in the current sweep.
REQ-012 o_err_cnt  output  9  number of mismatching vectors, 0..256.
REQ-013 o_first_x  output  8  o_x value at the first mismatch.
REQ-014 o_first_dknf / o_first_ddnf  output  5 each  sampled i_y_dknf / i_y_ddnf at the first mismatch.

Function
REQ-015 FSM states: IDLE, SETTLE, COMPARE, DONE; exactly one state is active per cycle.
REQ-016 IDLE or DONE with i_start=1 clears o_error, o_err_cnt, o_first_* and o_done, sets o_x=0, loads the settle counter with SETTLE_CYC-1, and goes to SETTLE.
REQ-017 SETTLE holds o_x constant and decrements the settle counter; it goes to COMPARE on the cycle the counter equals 0.
REQ-018 COMPARE samples i_y_dknf and i_y_ddnf in a single cycle; a mismatch is i_y_dknf != i_y_ddnf over all 5 bits.
REQ-019 On a mismatch, o_err_cnt increments by 1 and o_error is set.
REQ-020 o_first_x, o_first_dknf and o_first_ddnf capture only when o_err_cnt was 0 before the compare; later mismatches do not overwrite them.
REQ-021 After COMPARE, the FSM goes to DONE if o_x==8'hFF, or if STOP_ON_ERR=1 and the compare mismatched; in that case o_x is held.
REQ-022 After COMPARE in all other cases, o_x increments by 1, the settle counter reloads, and the FSM goes to SETTLE.
REQ-023 o_x never wraps within a sweep, and exactly 256 compares occur when STOP_ON_ERR=0.
REQ-024 Full-sweep latency from the i_start cycle to o_done=1 is 256*(SETTLE_CYC+1)+1 clocks when STOP_ON_ERR=0.
REQ-025 o_busy is 1 in SETTLE and COMPARE, and 0 otherwise.
REQ-026 i_start while busy is ignored and does not restart the sweep.
REQ-027 o_err_cnt saturates at 256 and never wraps.
REQ-028 All outputs are registered, with no combinational path from i_y_* to any output.

Reset
REQ-029 rst=1 forces state IDLE immediately, regardless of clk.
REQ-030 During rst=1: o_x=0, o_busy=0, o_done=0, o_error=0, o_err_cnt=0, o_first_x=0, o_first_dknf=0, o_first_ddnf=0.
REQ-031 rst asserted mid-sweep aborts the sweep with no partial results retained.
REQ-032 After rst deasserts, the block stays in IDLE until i_start=1.

Verification
REQ-033 Identical implementations (i_y_ddnf tied to i_y_dknf), SETTLE_CYC=2, pulse i_start -> o_done=1 exactly 769 clocks later, o_error=0, o_err_cnt=0, o_x=8'hFF.
REQ-034 i_y_ddnf differs only when o_x==8'h5A (bit0 inverted), STOP_ON_ERR=0 -> o_err_cnt=1, o_first_x=8'h5A, o_first_dknf^o_first_ddnf=5'b00001, o_x=8'hFF at done.
REQ-035 Mismatch at o_x==8'h10 and 8'h20, STOP_ON_ERR=1 -> o_done with o_x=8'h10, o_err_cnt=1, no compare performed at 8'h20.
REQ-036 i_y_ddnf=~i_y_dknf for all vectors -> o_err_cnt=256 (9'h100), o_first_x=8'h00.
REQ-037 rst asserted asynchronously at o_x==8'h80 -> all outputs 0 before the next posedge; a new i_start gives a clean sweep from 8'h00.
REQ-038 i_start pulsed every cycle during a sweep -> no restart, latency unchanged; i_start in DONE starts a fresh sweep with o_error, o_err_cnt and o_first_* cleared.
